// File: rtl/axi_pack.sv
// Shared AXI4 field types and the write-arbiter state encoding.
package axi_pack;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    typedef logic [LEN_W-1:0]   len_type;
    typedef logic [SIZE_W-1:0]  size_type;
    typedef logic [BURST_W-1:0] burst_type;
    typedef logic [RESP_W-1:0]  resp_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_arb_state_t;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after ptr wins.
module axi_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_req
);

    localparam int IDX_W = $clog2(N);

    int               idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            cand = IDX_W'(idx);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW, W, B) among NUM_MASTERS requesters.
// One transaction is routed end-to-end before the next grant; no buffering on any channel.
//
// state | meaning
// IDLE  | no owner; arbitrate among s_awvalid starting at rr_ptr
// ADDR  | owner's AW passed through to the slave
// DATA  | owner's W burst passed through; beat_cnt counts down from awlen
// RESP  | slave B routed to the owner; rr_ptr rotates on handshake
module axi_wr_arbiter
    import axi_pack::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_MASTERS-1:0]              s_awvalid,
    output logic [NUM_MASTERS-1:0]              s_awready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       s_awaddr,
    input  logic [NUM_MASTERS*ID_W-1:0]         s_awid,
    input  logic [NUM_MASTERS*LEN_W-1:0]        s_awlen,
    input  logic [NUM_MASTERS*SIZE_W-1:0]       s_awsize,
    input  logic [NUM_MASTERS*BURST_W-1:0]      s_awburst,
    input  logic [NUM_MASTERS-1:0]              s_wvalid,
    output logic [NUM_MASTERS-1:0]              s_wready,
    input  logic [NUM_MASTERS*DATA_W-1:0]       s_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   s_wstrb,
    input  logic [NUM_MASTERS-1:0]              s_wlast,
    output logic [NUM_MASTERS-1:0]              s_bvalid,
    input  logic [NUM_MASTERS-1:0]              s_bready,
    output logic [RESP_W-1:0]                   s_bresp,
    output logic [ID_W-1:0]                     s_bid,
    output logic                                m_awvalid,
    input  logic                                m_awready,
    output logic [ADDR_W-1:0]                   m_awaddr,
    output logic [ID_W-1:0]                     m_awid,
    output logic [LEN_W-1:0]                    m_awlen,
    output logic [SIZE_W-1:0]                   m_awsize,
    output logic [BURST_W-1:0]                  m_awburst,
    output logic                                m_wvalid,
    input  logic                                m_wready,
    output logic [DATA_W-1:0]                   m_wdata,
    output logic [DATA_W/8-1:0]                 m_wstrb,
    output logic                                m_wlast,
    input  logic                                m_bvalid,
    output logic                                m_bready,
    input  logic [RESP_W-1:0]                   m_bresp,
    input  logic [ID_W-1:0]                     m_bid,
    output logic [$clog2(NUM_MASTERS)-1:0]      grant,
    output logic                                busy,
    output logic                                err_wlast
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0]  aw_addr  [NUM_MASTERS];
    logic [ID_W-1:0]    aw_id    [NUM_MASTERS];
    len_type            aw_len   [NUM_MASTERS];
    size_type           aw_size  [NUM_MASTERS];
    burst_type          aw_burst [NUM_MASTERS];
    logic [DATA_W-1:0]  w_data   [NUM_MASTERS];
    logic [STRB_W-1:0]  w_strb   [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign aw_addr[i]  = s_awaddr[i*ADDR_W +: ADDR_W];
        assign aw_id[i]    = s_awid[i*ID_W +: ID_W];
        assign aw_len[i]   = s_awlen[i*LEN_W +: LEN_W];
        assign aw_size[i]  = s_awsize[i*SIZE_W +: SIZE_W];
        assign aw_burst[i] = s_awburst[i*BURST_W +: BURST_W];
        assign w_data[i]   = s_wdata[i*DATA_W +: DATA_W];
        assign w_strb[i]   = s_wstrb[i*STRB_W +: STRB_W];
    end

    wr_arb_state_t    state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    len_type          beat_cnt;
    logic             last_beat;
    logic             aw_hs, w_hs, b_hs;

    axi_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req     (s_awvalid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Payload follows the owner unconditionally; only the handshakes are state-gated.
    assign m_awaddr  = aw_addr[grant];
    assign m_awid    = aw_id[grant];
    assign m_awlen   = aw_len[grant];
    assign m_awsize  = aw_size[grant];
    assign m_awburst = aw_burst[grant];
    assign m_wdata   = w_data[grant];
    assign m_wstrb   = w_strb[grant];
    assign s_bresp   = m_bresp;
    assign s_bid     = m_bid;

    assign last_beat = (beat_cnt == '0);
    assign m_wlast   = (state == DATA) && last_beat;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        err_wlast = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = ADDR;
            end
            ADDR: begin
                m_awvalid        = s_awvalid[grant];
                s_awready[grant] = m_awready;
                aw_hs            = s_awvalid[grant] && m_awready;
                if (aw_hs) state_nxt = DATA;
            end
            DATA: begin
                m_wvalid        = s_wvalid[grant];
                s_wready[grant] = m_wready;
                w_hs            = s_wvalid[grant] && m_wready;
                if (w_hs) begin
                    // awlen governs the burst; a wrong s_wlast is only reported
                    err_wlast = (s_wlast[grant] != last_beat);
                    if (last_beat) state_nxt = RESP;
                end
            end
            RESP: begin
                s_bvalid[grant] = m_bvalid;
                m_bready        = s_bready[grant];
                b_hs            = m_bvalid && s_bready[grant];
                if (b_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) grant <= winner;
            if (aw_hs) beat_cnt <= aw_len[grant];
            else if (w_hs && !last_beat) beat_cnt <= beat_cnt - LEN_W'(1);
            if (b_hs) rr_ptr <= (grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant + IDX_W'(1);
        end
    end

endmodule
